pll_drp_ctrl: RTL and testbench

Runtime reconfiguration sequencer for the PLLE2_ADV inside the clock-management block. It drives the PLL's DRP port and RST pin to switch between a set of parameter-defined frequency configurations. It holds the PLL in reset, read-modify-writes each DRP register of the selected configuration, then releases reset and waits for LOCKED. It sits on the free-running input clock domain, never on the PLL output, and reports completion and error status to the SoC control logic.

---
 rtl/pll_drp_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// PLLE2_ADV runtime reconfiguration sequencer: holds the PLL in reset,
// read-modify-writes one DRP register table, then waits for lock.
module pll_drp_ctrl #(
  parameter int NUM_CFG = 2,
  parameter int ENTRIES = 4,
  parameter logic [NUM_CFG*ENTRIES*39-1:0] CFG_TABLE = '0,
  parameter int RST_HOLD = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536,
  localparam int CFG_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req_valid,
  input  logic [CFG_W-1:0] req_cfg,
  output logic             req_ready,
  output logic [6:0]       drp_daddr,
  output logic             drp_den,
  output logic             drp_dwe,
  output logic [15:0]      drp_di,
  input  logic [15:0]      drp_do,
  input  logic             drp_drdy,
  output logic             pll_rst,
  input  logic             pll_locked,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code
);

  localparam int K_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int C_MAX1 = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
  localparam int C_MAX = (C_MAX1 > LOCK_TIMEOUT) ? C_MAX1 : LOCK_TIMEOUT;
  localparam int CNT_W = $clog2(C_MAX + 1);

  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRDY_END = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_END = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(ENTRIES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_WAIT,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_WR_WAIT,
    S_LOCK_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic             locked_s;
  logic [CFG_W-1:0] cfg_q;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] cnt;

  logic [38:0] ent;
  logic [38:0] ent_nxt;
  logic [6:0]  ent_addr;
  logic [15:0] ent_mask;
  logic [15:0] ent_data;
  logic [15:0] rmw;
  int          base;
  int          nk;

  assign locked_s = sync_q[1];

  // Next-entry lookup lets WR_WAIT launch the following read with no gap.
  always_comb begin
    base = int'(cfg_q) * ENTRIES;
    nk = (k_q == K_LAST) ? 0 : int'(k_q) + 1;
    ent = CFG_TABLE[(base + int'(k_q))*39 +: 39];
    ent_nxt = CFG_TABLE[(base + nk)*39 +: 39];
  end

  assign {ent_addr, ent_mask, ent_data} = ent;
  assign rmw = (drp_do & ent_mask) | ent_data;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= S_IDLE;
      sync_q    <= 2'b00;
      cfg_q     <= '0;
      k_q       <= '0;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_code  <= 2'd0;
      pll_rst   <= 1'b0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= 7'd0;
      drp_di    <= 16'd0;
    end else begin
      sync_q  <= {sync_q[0], pll_locked};
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;
      done    <= 1'b0;
      cnt     <= cnt + 1'b1;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            err_code  <= 2'd0;
            k_q       <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            if (int'(req_cfg) >= NUM_CFG) begin
              err_code <= 2'd1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              cfg_q   <= req_cfg;
              pll_rst <= 1'b1;
              state   <= S_RST_WAIT;
            end
          end
        end
        S_RST_WAIT: begin
          if (cnt == RST_END) begin
            drp_den   <= 1'b1;
            drp_daddr <= ent_addr;
            state     <= S_RD;
          end
        end
        S_RD: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drp_drdy) begin
            drp_den   <= 1'b1;
            drp_dwe   <= 1'b1;
            drp_daddr <= ent_addr;
            drp_di    <= rmw;
            state     <= S_WR;
          end else if (cnt == DRDY_END) begin
            err_code <= 2'd2;
            pll_rst  <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_WR: begin
          cnt   <= '0;
          state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
            cnt <= '0;
            if (k_q == K_LAST) begin
              pll_rst <= 1'b0;
              state   <= S_LOCK_WAIT;
            end else begin
              k_q       <= k_q + 1'b1;
              drp_den   <= 1'b1;
              drp_daddr <= ent_nxt[38:32];
              state     <= S_RD;
            end
          end else if (cnt == DRDY_END) begin
            err_code <= 2'd2;
            pll_rst  <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_LOCK_WAIT: begin
          if (locked_s) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (cnt == LOCK_END) begin
            err_code <= 2'd3;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Directed bench for pll_drp_ctrl with a behavioural DRP/PLL model.
module tb_pll_drp_ctrl;

  localparam int NCFG = 3;
  localparam int NENT = 4;
  localparam int RH = 4;
  localparam int DT = 16;
  localparam int LT = 100;

  localparam logic [NCFG*NENT*39-1:0] TABLE = {
    {7'h23, 16'h0000, 16'h2223}, {7'h22, 16'h0000, 16'h2222},
    {7'h21, 16'h0000, 16'h2221}, {7'h20, 16'h0000, 16'h2220},
    {7'h0B, 16'h00F0, 16'h0100}, {7'h0A, 16'hFF00, 16'h0011},
    {7'h09, 16'h0F0F, 16'h3030}, {7'h08, 16'h1000, 16'h0145},
    {7'h13, 16'hFFFF, 16'h0000}, {7'h12, 16'h0000, 16'h5A5A},
    {7'h11, 16'hF000, 16'h0ABC}, {7'h10, 16'h00FF, 16'h1200}
  };

  logic        clk;
  logic        rst_in;
  logic        req_valid;
  logic [1:0]  req_cfg;
  logic        req_ready;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        pll_rst;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;

  pll_drp_ctrl #(
    .NUM_CFG(NCFG),
    .ENTRIES(NENT),
    .CFG_TABLE(TABLE),
    .RST_HOLD(RH),
    .DRDY_TIMEOUT(DT),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .req_valid(req_valid),
    .req_cfg(req_cfg),
    .req_ready(req_ready),
    .drp_daddr(drp_daddr),
    .drp_den(drp_den),
    .drp_dwe(drp_dwe),
    .drp_di(drp_di),
    .drp_do(drp_do),
    .drp_drdy(drp_drdy),
    .pll_rst(pll_rst),
    .pll_locked(pll_locked),
    .busy(busy),
    .done(done),
    .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // DRP slave model and access monitor
  logic [15:0] mem [128];
  logic [6:0]  ev_addr [$];
  logic        ev_we [$];
  logic [15:0] ev_di [$];
  logic        ev_rst [$];
  int          ev_cyc [$];
  int  n_overlap = 0;
  int  n_long = 0;
  int  lat_fix = 1;
  bit  vary = 0;
  int  lat_tab [3] = '{1, 3, 7};
  int  acc_n = 0;
  int  rd_n = 0;
  int  hold_rd = -1;
  bit  pend = 0;
  bit  drop = 0;
  int  rem = 0;
  logic [6:0]  p_addr = '0;
  logic        p_we = 1'b0;
  logic [15:0] p_di = '0;
  logic prev_den = 1'b0;
  logic prev_rst = 1'b0;
  int  rst_fall = 0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hFFFF;
    drp_do = 16'h0;
    drp_drdy = 1'b0;
  end

  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (!rst_in) begin
      pend = 0;
    end else begin
      if (pend) begin
        rem--;
        if (rem == 0) begin
          pend = 0;
          if (!drop) begin
            drp_drdy = 1'b1;
            drp_do = mem[p_addr];
            if (p_we) mem[p_addr] = p_di;
          end
        end
      end
      if (drp_den) begin
        if (pend) n_overlap++;
        if (prev_den) n_long++;
        ev_addr.push_back(drp_daddr);
        ev_we.push_back(drp_dwe);
        ev_di.push_back(drp_di);
        ev_rst.push_back(pll_rst);
        ev_cyc.push_back(cyc);
        drop = 0;
        if (!drp_dwe) begin
          if (rd_n == hold_rd) drop = 1;
          rd_n++;
        end
        pend = 1;
        rem = vary ? lat_tab[acc_n % 3] : lat_fix;
        acc_n++;
        p_addr = drp_daddr;
        p_we = drp_dwe;
        p_di = drp_di;
      end
      if (prev_rst && !pll_rst) rst_fall = cyc;
    end
    prev_den = drp_den;
    prev_rst = pll_rst;
  end

  // PLL lock model: locks ~20 cycles after reset release
  bit lock_en = 1;
  int lc = 0;
  int lock_rise = 0;
  initial pll_locked = 1'b0;
  always @(negedge clk) begin
    if (pll_rst || !lock_en) begin
      pll_locked = 1'b0;
      lc = 0;
    end else if (lc < 20) begin
      lc++;
    end else if (!pll_locked) begin
      pll_locked = 1'b1;
      lock_rise = cyc;
    end
  end

  int acc_cyc;
  int done_cyc;
  logic [6:0]  exp_a [4];
  logic [15:0] exp_d [4];

  task automatic clear_ev();
    ev_addr.delete();
    ev_we.delete();
    ev_di.delete();
    ev_rst.delete();
    ev_cyc.delete();
    rd_n = 0;
    acc_n = 0;
    n_overlap = 0;
    n_long = 0;
  endtask

  task automatic issue(input logic [1:0] c);
    @(negedge clk);
    req_cfg = c;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
    done_cyc = cyc;
  endtask

  task automatic check_seq();
    check("n_acc", ev_addr.size(), 8);
    if (ev_addr.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("addr", ev_addr[i], exp_a[i/2]);
        check("we", ev_we[i], 32'(i % 2));
        check("rst_hi", ev_rst[i], 1);
        if (i % 2 == 1) check("di", ev_di[i], exp_d[i/2]);
      end
    end
    check("overlap", n_overlap, 0);
    check("den_long", n_long, 0);
  endtask

  task automatic check_reset_vals();
    check("rst_den", drp_den, 0);
    check("rst_dwe", drp_dwe, 0);
    check("rst_addr", drp_daddr, 0);
    check("rst_di", drp_di, 0);
    check("rst_pll", pll_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
  endtask

  initial begin
    int n;
    int nd;
    rst_in = 1'b0;
    req_valid = 1'b0;
    req_cfg = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_in = 1'b1;
    repeat (25) @(negedge clk);

    // config 1, DRDY after one cycle
    clear_ev();
    issue(2'd1);
    check("busy_acc", busy, 1);
    check("pll_rst_rise", pll_rst, 1);
    wait_done(200);
    check("ok_err", err_code, 0);
    check("busy_at_done", busy, 1);
    check("lock_lat", done_cyc - lock_rise, 3);
    if (ev_cyc.size() > 0) check("rst_hold", ev_cyc[0] - acc_cyc, RH);
    exp_a = '{7'h08, 7'h09, 7'h0A, 7'h0B};
    exp_d = '{16'h1145, 16'h3F3F, 16'hFF11, 16'h01F0};
    check_seq();
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("ready_after", req_ready, 1);

    // config 0, varied DRDY latency
    clear_ev();
    vary = 1;
    issue(2'd0);
    wait_done(300);
    check("vary_err", err_code, 0);
    exp_a = '{7'h10, 7'h11, 7'h12, 7'h13};
    exp_d = '{16'h12FF, 16'hFABC, 16'h5A5A, 16'hFFFF};
    check_seq();
    vary = 0;
    @(negedge clk);

    // out-of-range index
    clear_ev();
    issue(2'd3);
    check("bad_done", done, 1);
    check("bad_err", err_code, 1);
    check("bad_pll", pll_rst, 0);
    @(negedge clk);
    check("bad_done_low", done, 0);
    check("bad_idle", busy, 0);
    check("bad_no_den", ev_addr.size(), 0);

    // DRDY withheld on second read
    clear_ev();
    hold_rd = 1;
    issue(2'd2);
    wait_done(200);
    check("drdy_err", err_code, 2);
    check("drdy_pll", pll_rst, 0);
    check("drdy_n", ev_addr.size(), 3);
    if (ev_cyc.size() == 3) check("drdy_time", done_cyc - ev_cyc[2], DT + 1);
    repeat (20) @(negedge clk);
    check("drdy_quiet", ev_addr.size(), 3);
    hold_rd = -1;

    // lock never arrives, then recovery
    clear_ev();
    lock_en = 0;
    issue(2'd2);
    wait_done(400);
    check("lock_err", err_code, 3);
    check("lock_time", done_cyc - rst_fall, LT);
    lock_en = 1;
    @(negedge clk);
    issue(2'd1);
    check("err_cleared", err_code, 0);
    wait_done(200);
    check("recov_err", err_code, 0);
    @(negedge clk);

    // async reset during WR_WAIT
    clear_ev();
    lat_fix = 7;
    issue(2'd0);
    n = 0;
    while (!(drp_den && drp_dwe) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wr_seen", drp_den & drp_dwe, 1);
    @(negedge clk);
    #2 rst_in = 1'b0;
    #1 check_reset_vals();
    nd = ev_addr.size();
    repeat (10) @(negedge clk);
    check("rst_quiet", ev_addr.size(), nd);
    rst_in = 1'b1;
    lat_fix = 1;
    @(negedge clk);
    clear_ev();
    issue(2'd1);
    check("post_rst_acc", busy, 1);
    wait_done(200);
    check("post_rst_err", err_code, 0);
    check("post_rst_n", ev_addr.size(), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
